// File: rtl/mc_datapath_if.sv
// mc_datapath_if: instruction and data memory req/ready buses between the core (master) and memories (slave).
interface mc_datapath_if #(
    parameter int IM_ADDR_W = 10,
    parameter int DM_ADDR_W = 10
);
    logic                 im_req;
    logic [IM_ADDR_W-1:0] im_addr;
    logic                 im_ready;
    logic [31:0]          im_rdata;
    logic                 dm_req;
    logic                 dm_we;
    logic [DM_ADDR_W-1:0] dm_addr;
    logic [31:0]          dm_wdata;
    logic                 dm_ready;
    logic [31:0]          dm_rdata;

    modport master (
        output im_req, im_addr, dm_req, dm_we, dm_addr, dm_wdata,
        input  im_ready, im_rdata, dm_ready, dm_rdata
    );

    modport slave (
        input  im_req, im_addr, dm_req, dm_we, dm_addr, dm_wdata,
        output im_ready, im_rdata, dm_ready, dm_rdata
    );
endinterface

// File: rtl/mc_datapath.sv
// mc_datapath: multi-cycle MIPS-lite core (FSM, datapath, 32x32 GPRs); OVERFLOW_TRAP_EN enables the add/addi overflow trap.
module mc_datapath #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter int          IM_ADDR_W = 10,
    parameter int          DM_ADDR_W = 10
) (
    input  logic          clk,
    input  logic          rst,
    mc_datapath_if.master bus,
    output logic [31:0]   pc,
    output logic [2:0]    state,
    output logic          retire,
    output logic          illegal,
    output logic          overflow
);
    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_ERR = 3'd5
    } state_t;

    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_ORI = 6'h0D, OP_LUI = 6'h0F;
    localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_JR = 6'h08, FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_SLT = 6'h2A;

    state_t      r_state;
    logic [31:0] r_pc, r_pc4, r_ir, r_a, r_b, r_alu, r_mdr;
    logic        r_im_req, r_dm_req, r_illegal;
    logic [31:0] r_gpr [32];
`ifdef OVERFLOW_TRAP_EN
    logic        r_ovf;
`endif

    logic [5:0]  w_op, w_fn;
    logic [4:0]  w_rs, w_rt, w_dst;
    logic [15:0] w_imm;
    logic [31:0] w_sext, w_opb, w_sum, w_alu, w_jpc, w_res;
    logic        w_rtype, w_legal, w_jump, w_mem;

    assign w_op    = r_ir[31:26];
    assign w_rs    = r_ir[25:21];
    assign w_rt    = r_ir[20:16];
    assign w_fn    = r_ir[5:0];
    assign w_imm   = r_ir[15:0];
    assign w_rtype = w_op == OP_R;
    assign w_sext  = {{16{w_imm[15]}}, w_imm};
    assign w_dst   = w_rtype ? r_ir[15:11] : w_rt;
    assign w_legal = w_rtype ? (w_fn inside {FN_JR, FN_ADD, FN_ADDU, FN_SUBU, FN_SLT})
                             : (w_op inside {OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI, OP_LW, OP_SW});
    assign w_jump  = (w_op inside {OP_J, OP_JAL, OP_BEQ}) || (w_rtype && w_fn == FN_JR);
    assign w_mem   = w_op == OP_LW || w_op == OP_SW;

    // ori zero-extends its immediate; every other I-type sign-extends
    assign w_opb = w_rtype ? r_b : (w_op == OP_ORI ? {16'h0, w_imm} : w_sext);
    assign w_sum = r_a + w_opb;
    assign w_alu = w_op == OP_LUI             ? {w_imm, 16'h0} :
                   w_op == OP_ORI             ? r_a | w_opb :
                   w_rtype && w_fn == FN_SUBU ? r_a - r_b :
                   w_rtype && w_fn == FN_SLT  ? {31'h0, $signed(r_a) < $signed(r_b)} : w_sum;
    assign w_jpc = w_op == OP_BEQ ? (r_a == r_b ? r_pc4 + {w_sext[29:0], 2'b00} : r_pc4) :
                   w_rtype        ? r_a : {r_pc4[31:28], r_ir[25:0], 2'b00};
    assign w_res = w_op == OP_LW ? r_mdr : r_alu;

`ifdef OVERFLOW_TRAP_EN
    logic w_add_ovf;
    assign w_add_ovf = ((w_rtype && w_fn == FN_ADD) || w_op == OP_ADDI) &&
                       r_a[31] == w_opb[31] && w_sum[31] != r_a[31];
    assign overflow  = r_state == S_WB && r_ovf;
`else
    assign overflow  = 1'b0;
`endif

    assign retire = (r_state == S_EXEC && w_jump) || r_state == S_WB ||
                    (r_state == S_MEM && w_op == OP_SW && bus.dm_ready);

    assign bus.im_req   = r_im_req;
    assign bus.im_addr  = r_pc[IM_ADDR_W+1:2];
    assign bus.dm_req   = r_dm_req;
    assign bus.dm_we    = w_op == OP_SW;
    assign bus.dm_addr  = r_alu[DM_ADDR_W+1:2];
    assign bus.dm_wdata = r_b;
    assign pc      = r_pc;
    assign state   = r_state;
    assign illegal = r_illegal;

    // Controller and datapath registers; request lines are registered and raised on entry to FETCH/MEM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_pc4     <= '0;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_alu     <= '0;
            r_mdr     <= '0;
            r_im_req  <= 1'b1;
            r_dm_req  <= 1'b0;
            r_illegal <= 1'b0;
            for (int i = 0; i < 32; i++) r_gpr[i] <= '0;
`ifdef OVERFLOW_TRAP_EN
            r_ovf     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_FETCH: if (bus.im_ready) begin
                    r_ir     <= bus.im_rdata;
                    r_pc4    <= r_pc + 32'd4;
                    r_im_req <= 1'b0;
                    r_state  <= S_DECODE;
                end
                S_DECODE: begin
                    r_a       <= r_gpr[w_rs];
                    r_b       <= r_gpr[w_rt];
                    r_illegal <= !w_legal;
                    r_state   <= w_legal ? S_EXEC : S_ERR;
                end
                S_EXEC: begin
                    r_alu <= w_alu;
`ifdef OVERFLOW_TRAP_EN
                    r_ovf <= w_add_ovf;
`endif
                    if (w_jump) begin
                        r_pc     <= w_jpc;
                        r_im_req <= 1'b1;
                        r_state  <= S_FETCH;
                        if (w_op == OP_JAL) r_gpr[31] <= r_pc4;
                    end else begin
                        r_dm_req <= w_mem;
                        r_state  <= w_mem ? S_MEM : S_WB;
                    end
                end
                S_MEM: if (bus.dm_ready) begin
                    r_dm_req <= 1'b0;
                    r_mdr    <= bus.dm_rdata;
                    if (w_op == OP_SW) begin
                        r_pc     <= r_pc4;
                        r_im_req <= 1'b1;
                        r_state  <= S_FETCH;
                    end else begin
                        r_state  <= S_WB;
                    end
                end
                S_WB: begin
`ifdef OVERFLOW_TRAP_EN
                    if (r_ovf) r_gpr[30] <= 32'd1; else
`endif
                    if (w_dst != 5'd0) r_gpr[w_dst] <= w_res;
                    r_pc     <= r_pc4;
                    r_im_req <= 1'b1;
                    r_state  <= S_FETCH;
                end
                default: r_state <= S_ERR;
            endcase
        end
    end
endmodule

// File: doc/mc_datapath.md
Name: mc_datapath

Overview:
- Multi-cycle MIPS-lite core: integrated FSM controller, datapath, and 32x32 register file.
- Replaces the single-cycle datapath. Each instruction takes 3-5 states.
- Instruction memory and data memory are external, each behind a req/ready handshake, so wait-stated memories are supported.
- Sits at top level between the clock/reset source and the im/dm memory blocks.

Parameters:
- RESET_PC, 32'h0000_3000: PC value loaded on reset.
- IM_ADDR_W, 10: word-address width driven on im_addr.
- DM_ADDR_W, 10: word-address width driven on dm_addr.

Ports:
- clk  in  1: single clock; all state updates on rising edge.
- rst  in  1: synchronous, active-high reset.
- im_req  out  1: instruction fetch request.
- im_addr  out  IM_ADDR_W: pc[IM_ADDR_W+1:2].
- im_ready  in  1: im_rdata valid; transfer when im_req & im_ready.
- im_rdata  in  32: instruction word.
- dm_req  out  1: data access request.
- dm_we  out  1: 1 = store, 0 = load; valid while dm_req.
- dm_addr  out  DM_ADDR_W: alu_out[DM_ADDR_W+1:2].
- dm_wdata  out  32: rt value for sw.
- dm_ready  in  1: access completes when dm_req & dm_ready.
- dm_rdata  in  32: load data, sampled on completion.
- pc  out  32: current instruction PC.
- state  out  3: FSM state encoding.
- retire  out  1: one-cycle pulse on the final cycle of each completed instruction.
- illegal  out  1: sticky; set on undecodable instruction.
- overflow  out  1: one-cycle pulse on signed-overflow trap.

Behaviour:
- Reset values on rst:
  - pc=RESET_PC; state=FETCH(0); IR, A, B, ALUOut, MDR = 0.
  - All 32 GPRs = 0.
  - illegal=0, retire=0, overflow=0.
  - dm_req=0. im_req=1 from the first cycle after the reset edge.
  - Reset mid-handshake abandons the transfer; no GPR or PC write occurs.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=5.
- FETCH:
  - im_req=1, held until im_ready.
  - On handshake: IR<=im_rdata, pc_plus4<=pc+4, go to DECODE.
- DECODE:
  - A<=GPR[rs], B<=GPR[rt].
  - Unsupported opcode/funct -> ERR.
  - Otherwise -> EXEC.
- EXEC, per instruction:
  - R-type / I-ALU: ALUOut computed -> WB.
  - lw/sw: ALUOut=A+sext(imm) -> MEM.
  - beq: if A==B, pc<=pc_plus4+(sext(imm)<<2), else pc<=pc_plus4; retire -> FETCH.
  - j: pc<={pc_plus4[31:28], idx, 2'b00}; retire -> FETCH.
  - jal: as j, plus $31<=pc_plus4; retire -> FETCH.
  - jr: pc<=A; retire -> FETCH.
- MEM:
  - dm_req=1, held until dm_ready; address and wdata stable while waiting.
  - sw: on completion pc<=pc_plus4, retire -> FETCH.
  - lw: MDR<=dm_rdata -> WB.
- WB:
  - GPR[dst]<=result; pc<=pc_plus4; retire -> FETCH.
  - dst = rd for R-type, rt for I-type and lw.
- ERR: sticky until rst; illegal=1; no requests issued.
- Supported R-type funct: addu 21, subu 23, add 20, slt 2A, jr 08.
- Supported opcodes: addi 08, addiu 09, ori 0D (zero-extended imm), lui 0F (imm<<16), lw 23, sw 2B, beq 04, j 02, jal 03.
- Arithmetic and register rules:
  - All arithmetic is 32-bit wrap except the overflow trap.
  - slt is signed, result 0/1.
  - Writes to $0 are discarded; $0 always reads 0.
- Cycle counts at zero wait states:
  - R/I-ALU 4; lw 5; sw 4; beq/j/jal/jr 3.
  - Each wait cycle on im_ready or dm_ready adds 1.
- Register file:
  - Written only in WB, plus jal in EXEC and the trap in WB.
  - Read-after-write across instructions is natural, since DECODE follows the earlier WB.

Optional Feature:
- Macro: OVERFLOW_TRAP_EN.
- Defined:
  - add/addi with signed overflow in WB do not write dst; instead $30<=32'd1.
  - overflow pulses 1 cycle; retire also pulses; pc<=pc_plus4.
- Undefined:
  - add/addi behave as addu/addiu (wrap, dst written).
  - overflow is tied 0.

Test Plan:
- Reset then zero-wait im preloaded with "ori $1,$0,0x5; ori $2,$0,0x7; addu $3,$1,$2" -> $3=12; retire at cycles 4, 8, 12; pc=RESET_PC+12.
- sw $3,4($0) then lw $4,4($0), with dm_ready delayed 2 cycles -> dm_req held 3 cycles with stable addr=1; $4=12; lw takes 7 cycles.
- beq $1,$1,-1 -> pc unchanged after 3 cycles, loops. beq $1,$2,+2 -> pc+4.
- jal at 0x3010 then jr $31 -> $31=0x3014; pc returns to 0x3014; $0 write attempt leaves $0=0.
- Opcode 0x3F -> state=ERR, illegal=1 sticky, im_req=0. Assert rst -> pc=RESET_PC, illegal=0.
- OVERFLOW_TRAP_EN: addi $5,$6,1 with $6=0x7FFFFFFF -> $5 unchanged, $30=1, overflow pulse. Without the macro -> $5=0x80000000, overflow=0.
